// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_EN.
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        blank,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        pend
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             tick;
  logic             frame;
  logic [31:0]      pend_data;
  logic [7:0]       pend_dp;
  logic [31:0]      disp_data;
  logic [7:0]       disp_dp;
  logic [3:0]       nibble;
  logic             lit;

  assign tick   = (cnt == CNT_MAX);
  assign frame  = tick && (idx == 3'd7);
  assign nibble = disp_data[{idx, 2'b00} +: 4];

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

`ifdef SEG_BLANK_EN
  logic [2:0] msd;

  // Digit 0 is always at or below msd, so it never goes dark.
  always_comb begin
    msd = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (disp_data[4*k +: 4] != 4'h0) msd = 3'(k);
    end
    lit = (idx <= msd) || disp_dp[idx];
  end
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= 3'd0;
      pend_data <= 32'h0;
      pend_dp   <= 8'h00;
      pend      <= 1'b0;
      disp_data <= 32'h0;
      disp_dp   <= 8'h00;
      an        <= 8'hFF;
      seg       <= 8'hFF;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 3'd1;

      // Display swaps only at the frame boundary; a coincident load lands in pending afterwards.
      if (frame && pend) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
        pend      <= 1'b0;
      end
      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        pend      <= 1'b1;
      end

      if (blank || !lit) begin
        an  <= 8'hFF;
        seg <= 8'hFF;
      end else begin
        an  <= ~(8'h01 << idx);
        seg <= {~disp_dp[idx], hex7(nibble)};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (CLK_DIV = 4): directed scenarios plus random loads/blanking,
// compared against a cycle-count based reference model.
module tb_seg_scan_ctrl;

  localparam int DIV = 4;
  localparam int FRAME = 8 * DIV;
  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic [7:0]  dp_in = 8'h00;
  logic        blank = 1'b0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        pend;

  int checks = 0;
  int errors = 0;

  // Reference model: n counts rising edges since reset release.
  int          n;
  logic [31:0] m_disp, m_pdata;
  logic [7:0]  m_ddp, m_pdp;
  logic        m_pend;

  seg_scan_ctrl #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank(blank), .an(an), .seg(seg), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_lit(input int k);
`ifdef SEG_BLANK_EN
    int top;
    top = 0;
    for (int j = 0; j < 8; j++) if (m_disp[4*j +: 4] != 4'h0) top = j;
    return (k <= top) || m_ddp[k];
`else
    return 1'b1;
`endif
  endfunction

  task automatic cyc(input logic l, input logic [31:0] d, input logic [7:0] p, input logic b);
    int k;
    logic [7:0] ea, es;
    load = l; data_in = d; dp_in = p; blank = b;
    @(posedge clk);
    k = (n / DIV) % 8;
    if (b || !model_lit(k)) begin
      ea = 8'hFF;
      es = 8'hFF;
    end else begin
      ea = ~(8'h01 << k);
      es = SEG_TAB[m_disp[4*k +: 4]];
      es[7] = ~m_ddp[k];
    end
    if ((n % FRAME) == FRAME - 1 && m_pend) begin
      m_disp = m_pdata;
      m_ddp  = m_pdp;
      m_pend = 1'b0;
    end
    if (l) begin
      m_pdata = d;
      m_pdp   = p;
      m_pend  = 1'b1;
    end
    n++;
    #1;
    chk("an", {24'h0, an}, {24'h0, ea});
    chk("seg", {24'h0, seg}, {24'h0, es});
    chk("pend", {31'h0, pend}, {31'h0, m_pend});
    load = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cyc(1'b0, 32'h0, 8'h00, 1'b0);
  endtask

  // Advance until the next edge happens at frame position pos (0..FRAME-1).
  task automatic go_to(input int pos);
    while ((n % FRAME) != pos) cyc(1'b0, 32'h0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    chk("rst_pend", {31'h0, pend}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_an", {24'h0, an}, 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    m_disp = 32'h0; m_ddp = 8'h00;
    m_pdata = 32'h0; m_pdp = 8'h00; m_pend = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  rp;
    logic        rb;

    do_reset();

    // Idle scan after reset
    idle(40);

    // Load mid-frame, shown from the next frame
    go_to(3 * DIV);
    cyc(1'b1, 32'h89ABCDEF, 8'h01, 1'b0);
    go_to(FRAME - 1);
    chk("pend_before_boundary", {31'h0, pend}, 32'h1);
    cyc(1'b0, 32'h0, 8'h00, 1'b0);
    chk("pend_after_boundary", {31'h0, pend}, 32'h0);
    cyc(1'b0, 32'h0, 8'h00, 1'b0);
    chk("digit0_seg", {24'h0, seg}, 32'h0E);
    chk("digit0_an", {24'h0, an}, 32'hFE);
    go_to(7 * DIV);
    cyc(1'b0, 32'h0, 8'h00, 1'b0);
    chk("digit7_seg", {24'h0, seg}, 32'h80);
    chk("digit7_an", {24'h0, an}, 32'h7F);

    // Two loads in one frame: last wins
    go_to(2);
    cyc(1'b1, 32'h11111111, 8'h00, 1'b0);
    go_to(20);
    cyc(1'b1, 32'h22222222, 8'h00, 1'b0);
    go_to(FRAME - 1);
    cyc(1'b0, 32'h0, 8'h00, 1'b0);
    cyc(1'b0, 32'h0, 8'h00, 1'b0);
    chk("last_load_wins", {24'h0, seg}, 32'hA4);
    idle(FRAME);

    // Load coincident with the frame boundary
    go_to(5);
    cyc(1'b1, 32'h33333333, 8'h00, 1'b0);
    go_to(FRAME - 1);
    cyc(1'b1, 32'h00000000, 8'h00, 1'b0);
    chk("coincident_pend", {31'h0, pend}, 32'h1);
    cyc(1'b0, 32'h0, 8'h00, 1'b0);
    chk("coincident_old_value", {24'h0, seg}, 32'hB0);
    go_to(FRAME - 1);
    cyc(1'b0, 32'h0, 8'h00, 1'b0);
    chk("coincident_pend_clear", {31'h0, pend}, 32'h0);
    cyc(1'b0, 32'h0, 8'h00, 1'b0);
    chk("coincident_new_value", {24'h0, seg}, 32'hC0);

    // Leading-zero blanking (or its absence)
    go_to(1);
    cyc(1'b1, 32'h00000A05, 8'h00, 1'b0);
    go_to(FRAME - 1);
    cyc(1'b0, 32'h0, 8'h00, 1'b0);
    go_to(2 * DIV);
    cyc(1'b0, 32'h0, 8'h00, 1'b0);
    chk("digit2_seg", {24'h0, seg}, 32'h88);
    go_to(4 * DIV);
    cyc(1'b0, 32'h0, 8'h00, 1'b0);
`ifdef SEG_BLANK_EN
    chk("digit4_an", {24'h0, an}, 32'hFF);
    chk("digit4_seg", {24'h0, seg}, 32'hFF);
`else
    chk("digit4_an", {24'h0, an}, 32'hEF);
    chk("digit4_seg", {24'h0, seg}, 32'hC0);
`endif
    idle(FRAME);

    // Blank mid-frame with a pending load, then reset
    go_to(2);
    cyc(1'b1, 32'h44444444, 8'hF0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 32'h0, 8'h00, 1'b1);
      chk("blank_an", {24'h0, an}, 32'hFF);
    end
    chk("pend_before_reset", {31'h0, pend}, 32'h1);
    do_reset();
    idle(FRAME + 8);

    // Random loads and blanking
    for (int i = 0; i < 400; i++) begin
      rd = $urandom;
      rp = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rd = rd >> (4 * $urandom_range(0, 7));
      rb = ($urandom_range(0, 5) == 0);
      cyc($urandom_range(0, 11) == 0, rd, rp, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 100000, clocks per digit slot; legal range 1..2^20.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 load  in  1  single-cycle strobe; captures data_in and dp_in into the pending buffer.
REQ-005 data_in  in  32  eight hex nibbles; nibble k (bits 4k+3:4k) drives digit k.
REQ-006 dp_in  in  8  decimal-point request per digit, active-high; bit k drives digit k.
REQ-007 blank  in  1  level; 1 forces all anodes off.
REQ-008 an  out  8  digit anode enables, active-low, one-hot-low when lit.
REQ-009 seg  out  8  segment drive, active-low; bit 7 is DP, bits 6:0 are g..a.
REQ-010 pend  out  1  high while a loaded value awaits the frame boundary.

Function
REQ-011 Prescaler cnt SHALL count 0..CLK_DIV-1 and wrap; tick SHALL assert in the cycle where cnt == CLK_DIV-1.
REQ-012 With CLK_DIV = 1, tick SHALL assert every cycle.
REQ-013 Digit index idx (3 bits) SHALL advance by 1 on each tick and wrap from 7 to 0.
REQ-014 Frame boundary SHALL be a tick with idx == 7.
REQ-015 load SHALL write data_in/dp_in into the pending registers and set pend to 1; a load while pend = 1 SHALL overwrite, last value wins.
REQ-016 On a frame boundary with pend = 1, the display registers SHALL take the pending value and pend SHALL clear.
REQ-017 load coincident with a frame boundary: the transfer SHALL use the pre-edge pending value, the new value SHALL enter pending, and pend SHALL remain 1.
REQ-018 Nibble of the display register selected by idx SHALL be decoded with the team's standard hex-to-segment table (0 -> 0xC0, 8 -> 0x80, F -> 0x8E, DP bit off).
REQ-019 seg[7] SHALL equal the inverse of the selected display DP bit; seg[6:0] SHALL come from the decoder.
REQ-020 an and seg SHALL be registered; they SHALL reflect idx exactly one cycle after idx changes.
REQ-021 an SHALL be ~(1 << idx) when lit; when blank = 1 or the digit is blanked (REQ-026), an SHALL be 8'hFF and seg SHALL be 8'hFF.
REQ-022 blank SHALL NOT stop cnt, idx or the pending transfer.
REQ-023 The display SHALL never show a mix of old and new values within one frame.

Reset
REQ-024 While rst_n = 0: cnt = 0, idx = 0, display data = 0, display DP = 0, pending = 0, pend = 0, an = 8'hFF, seg = 8'hFF.
REQ-025 Reset asserted mid-frame or with pend = 1 SHALL discard the pending value; after release, scanning SHALL restart at digit 0 with a full CLK_DIV slot.

Configuration
REQ-026 Macro SEG_BLANK_EN defined: leading-zero blanking SHALL apply. Digits above the most significant non-zero nibble SHALL be dark unless their DP bit is set; digit 0 SHALL always be lit.
REQ-027 SEG_BLANK_EN undefined: all eight digits SHALL be lit and the blanking logic SHALL be absent.

Verification (CLK_DIV = 4)
REQ-028 Reset release, then 40 cycles with no load -> an walks FE,FD,...,7F,FE with each value held 4 cycles; seg = C0 throughout; pend = 0.
REQ-029 load data_in = 0x89ABCDEF, dp_in = 0x01 at idx = 3 -> pend = 1 until the idx 7 -> 0 tick. Next frame shows digit 0 seg = 0x0E and digit 7 seg = 0x80.
REQ-030 Two loads in one frame, 0x11111111 then 0x22222222 -> only 0x22222222 is displayed; 0x11111111 never appears on seg.
REQ-031 load 0x00000000 in the same cycle as the frame boundary, with pending = 0x33333333 -> frame shows 3s; pend stays 1; the following frame shows 0s.
REQ-032 With SEG_BLANK_EN and data 0x00000A05 -> an lit only for digits 0..2; digits 3..7 read FF. Without SEG_BLANK_EN -> all eight digits lit, and digits 3..7 show seg = C0.
REQ-033 blank = 1 for 10 cycles mid-frame, then rst_n low for 1 cycle while pend = 1 -> an = FF during blank while idx keeps advancing. Reset returns all outputs to REQ-024 values; pend = 0.
